// File: rtl/div_if.sv
// Divider request/result bundle shared between a controller (master) and div (slave).
// Latency: none, wires only.
// Backpressure: none; the master must watch busy_o, and starts it issues while busy_o is high are dropped.
// Signals: a_bi/b_bi operands, start_i request, busy_o while working,
//          y_bo/r_bo quotient/remainder, dz_o divide-by-zero, done_o result pulse.
interface div_if #(
  parameter int A_W = 16,
  parameter int B_W = 8
);
  logic [A_W-1:0] a_bi;
  logic [B_W-1:0] b_bi;
  logic           start_i;
  logic           busy_o;
  logic [A_W-1:0] y_bo;
  logic [B_W-1:0] r_bo;
  logic           dz_o;
  logic           done_o;

  modport master (
    output a_bi, b_bi, start_i,
    input  busy_o, y_bo, r_bo, dz_o, done_o
  );

  modport slave (
    input  a_bi, b_bi, start_i,
    output busy_o, y_bo, r_bo, dz_o, done_o
  );
endinterface

// File: rtl/div.sv
// Sequential unsigned restoring divider, one quotient bit per clock (A_W/B_W -> A_W quotient, B_W remainder).
// Latency: A_W cycles from the start edge to done_o; a zero divisor completes on the start edge itself.
// Backpressure: start_i is honoured only while busy_o is low; it is dropped silently while busy_o is high.
// Ports: clk_i clock, rst_i async active-high reset, bus (div_if.slave): a_bi/b_bi operands,
//        start_i request, busy_o working, y_bo/r_bo held results, dz_o zero-divisor flag, done_o pulse.
module div #(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  div_if.slave bus
);

  localparam int CTR_W = $clog2(A_W);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(A_W - 1);

  typedef enum logic {IDLE = 1'b0, WORK = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CTR_W-1:0] ctr_q;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  // The partial remainder is always < b after a step, so B_W bits suffice;
  // only the trial value t needs the extra bit.
  logic [B_W-1:0] rem_q;
  logic [A_W-1:0] q_q;
  logic [A_W-1:0] y_q;
  logic [B_W-1:0] r_q;
  logic           dz_q;
  logic           done_q;

  logic [CTR_W-1:0] bit_idx;
  logic [B_W:0]     t;
  logic             ge;
  logic [B_W-1:0]   rem_d;
  logic [A_W-1:0]   q_d;
  logic             last;
  logic             b_zero;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    bit_idx = CTR_LAST - ctr_q;
    t       = {rem_q, a_q[bit_idx]};
    ge      = (t >= {1'b0, b_q});
    // When ge, t-b < b fits in B_W bits, so modulo-2^B_W subtraction is exact.
    rem_d   = ge ? (t[B_W-1:0] - b_q) : t[B_W-1:0];
    q_d          = q_q;
    q_d[bit_idx] = ge;
  end

  assign last   = (ctr_q == CTR_LAST);
  assign b_zero = (bus.b_bi == '0);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero divisor never leaves IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i && !b_zero) state_d = WORK;
      WORK:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy_o = (state_q == WORK);
    bus.y_bo   = y_q;
    bus.r_bo   = r_q;
    bus.dz_o   = dz_q;
    bus.done_o = done_q;
  end

  // Datapath and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctr_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      y_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (!b_zero) begin
              a_q   <= bus.a_bi;
              b_q   <= bus.b_bi;
              rem_q <= '0;
              q_q   <= '0;
              ctr_q <= '0;
            end else begin
              // Zero divisor: saturate the quotient and pass the low dividend bits through.
              y_q    <= '1;
              r_q    <= bus.a_bi[B_W-1:0];
              dz_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        WORK: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          if (last) begin
            ctr_q  <= '0;
            y_q    <= q_d;
            r_q    <= rem_d;
            dz_q   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
module tb_div;
  localparam int A_W = 16;
  localparam int B_W = 8;

  logic clk;
  logic rst;

  div_if #(.A_W(A_W), .B_W(B_W)) bus ();

  div #(.A_W(A_W), .B_W(B_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] y;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer division, zero divisor saturates.
  task automatic push_exp(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.y  = 16'hFFFF;
      e.r  = a[7:0];
      e.dz = 1'b1;
    end else begin
      e.y  = a / {8'd0, b};
      e.r  = 8'(a % {8'd0, b});
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    bus.a_bi    = a;
    bus.b_bi    = b;
    bus.start_i = 1'b1;
    push_exp(a, b);
    tick();
    bus.start_i = 1'b0;
  endtask

  // Waits (bounded) for done_o; n = edges waited, bc = samples with busy_o high.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = int'(bus.busy_o);
    while (!bus.done_o && n < 40) begin
      tick();
      n++;
      bc += int'(bus.busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.y_bo !== 16'd0) begin n_fail++; $display("FAIL reset_y: got %0h expected 0", bus.y_bo); end
    n_checks++; if (bus.r_bo !== 8'd0) begin n_fail++; $display("FAIL reset_r: got %0h expected 0", bus.r_bo); end
    n_checks++; if (bus.dz_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", bus.dz_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n, bc;
    exp_t e;
    start_op(16'd1000, 8'd7);
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b expected 1", bus.busy_o); end
    wait_done(n, bc);
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL basic_latency: got %0d expected 16", n); end
    n_checks++; if (bc != 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 16", bc); end
    e = sb.pop_front();
    n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL basic_y: got %0d expected %0d", bus.y_bo, e.y); end
    n_checks++; if (bus.r_bo !== e.r) begin n_fail++; $display("FAIL basic_r: got %0d expected %0d", bus.r_bo, e.r); end
    n_checks++; if (bus.dz_o !== e.dz) begin n_fail++; $display("FAIL basic_dz: got %b expected %b", bus.dz_o, e.dz); end
    n_checks++; if (32'(bus.y_bo) * 32'(e.b) + 32'(bus.r_bo) != 32'(e.a)) begin n_fail++; $display("FAIL basic_identity: got %0d expected %0d", 32'(bus.y_bo) * 32'(e.b) + 32'(bus.r_bo), e.a); end
    tick();
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL basic_y_held: got %0d expected %0d", bus.y_bo, e.y); end
  endtask

  task automatic test_patterns();
    logic [15:0] ta[10];
    logic [7:0]  tb_[10];
    int n, bc;
    exp_t e;
    ta[0] = 16'hFFFF; tb_[0] = 8'hFF;
    ta[1] = 16'hABCD; tb_[1] = 8'd1;
    ta[2] = 16'd100;  tb_[2] = 8'd200;
    ta[3] = 16'd0;    tb_[3] = 8'd13;
    for (int i = 4; i < 10; i++) begin
      ta[i]  = 16'($urandom);
      tb_[i] = 8'($urandom_range(1, 255));
    end
    for (int i = 0; i < 10; i++) begin
      start_op(ta[i], tb_[i]);
      wait_done(n, bc);
      e = sb.pop_front();
      n_checks++; if (n != 16) begin n_fail++; $display("FAIL pat%0d_latency: got %0d expected 16", i, n); end
      n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL pat%0d_y: a=%0h b=%0h got %0h expected %0h", i, e.a, e.b, bus.y_bo, e.y); end
      n_checks++; if (bus.r_bo !== e.r) begin n_fail++; $display("FAIL pat%0d_r: a=%0h b=%0h got %0h expected %0h", i, e.a, e.b, bus.r_bo, e.r); end
      n_checks++; if (bus.dz_o !== 1'b0) begin n_fail++; $display("FAIL pat%0d_dz: got %b expected 0", i, bus.dz_o); end
      n_checks++; if (!(bus.r_bo < e.b)) begin n_fail++; $display("FAIL pat%0d_r_lt_b: got %0d expected below %0d", i, bus.r_bo, e.b); end
      tick();
    end
  endtask

  task automatic test_div_by_zero();
    int n, bc;
    exp_t e;
    start_op(16'h1234, 8'd0);
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b expected 0", bus.busy_o); end
    wait_done(n, bc);
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL dz_latency: got %0d expected 0", n); end
    e = sb.pop_front();
    n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL dz_y: got %0h expected %0h", bus.y_bo, e.y); end
    n_checks++; if (bus.r_bo !== e.r) begin n_fail++; $display("FAIL dz_r: got %0h expected %0h", bus.r_bo, e.r); end
    n_checks++; if (bus.dz_o !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", bus.dz_o); end
    tick();
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL dz_done_pulse: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL dz_busy_after: got %b expected 0", bus.busy_o); end
    start_op(16'd9, 8'd3);
    wait_done(n, bc);
    e = sb.pop_front();
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL dz_next_latency: got %0d expected 16", n); end
    n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL dz_next_y: got %0d expected %0d", bus.y_bo, e.y); end
    n_checks++; if (bus.r_bo !== e.r) begin n_fail++; $display("FAIL dz_next_r: got %0d expected %0d", bus.r_bo, e.r); end
    n_checks++; if (bus.dz_o !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag: got %b expected 0", bus.dz_o); end
    tick();
  endtask

  task automatic test_start_ignored();
    int n, bc, extra;
    exp_t e;
    start_op(16'd500, 8'd3);
    repeat (5) tick();
    bus.a_bi    = 16'd1;
    bus.b_bi    = 8'd1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    wait_done(n, bc);
    e = sb.pop_front();
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL ign_latency: got %0d expected 10", n); end
    n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL ign_y: got %0d expected %0d", bus.y_bo, e.y); end
    n_checks++; if (bus.r_bo !== e.r) begin n_fail++; $display("FAIL ign_r: got %0d expected %0d", bus.r_bo, e.r); end
    extra = 0;
    repeat (20) begin
      tick();
      if (bus.done_o || bus.busy_o) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ign_no_second_op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    exp_t e1, e2;
    bus.a_bi    = 16'd1000;
    bus.b_bi    = 8'd7;
    bus.start_i = 1'b1;
    push_exp(16'd1000, 8'd7);
    tick();
    bus.a_bi = 16'd50;
    bus.b_bi = 8'd5;
    wait_done(n, bc);
    e1 = sb.pop_front();
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 16", n); end
    n_checks++; if (bus.y_bo !== e1.y) begin n_fail++; $display("FAIL b2b_first_y: got %0d expected %0d", bus.y_bo, e1.y); end
    push_exp(16'd50, 8'd5);
    tick();
    bus.start_i = 1'b0;
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b expected 1", bus.busy_o); end
    n_checks++; if (bus.y_bo !== e1.y) begin n_fail++; $display("FAIL b2b_prev_held: got %0d expected %0d", bus.y_bo, e1.y); end
    wait_done(n, bc);
    e2 = sb.pop_front();
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 16", n); end
    n_checks++; if (bus.y_bo !== e2.y) begin n_fail++; $display("FAIL b2b_second_y: got %0d expected %0d", bus.y_bo, e2.y); end
    n_checks++; if (bus.r_bo !== e2.r) begin n_fail++; $display("FAIL b2b_second_r: got %0d expected %0d", bus.r_bo, e2.r); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n, bc, seen;
    exp_t e;
    start_op(16'd1000, 8'd7);
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    e = sb.pop_back();
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy_o); end
    n_checks++; if (bus.y_bo !== 16'd0) begin n_fail++; $display("FAIL rstmid_y: got %0d expected 0", bus.y_bo); end
    n_checks++; if (bus.r_bo !== 8'd0) begin n_fail++; $display("FAIL rstmid_r: got %0d expected 0", bus.r_bo); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", bus.done_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.done_o) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
    start_op(16'd1000, 8'd7);
    wait_done(n, bc);
    e = sb.pop_front();
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL rstmid_after_latency: got %0d expected 16", n); end
    n_checks++; if (bus.y_bo !== e.y) begin n_fail++; $display("FAIL rstmid_after_y: got %0d expected %0d", bus.y_bo, e.y); end
    n_checks++; if (bus.r_bo !== e.r) begin n_fail++; $display("FAIL rstmid_after_r: got %0d expected %0d", bus.r_bo, e.r); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.a_bi    = '0;
    bus.b_bi    = '0;
    bus.start_i = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_div_by_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's shift-add multiplier (`mul`).
- Produces one quotient bit per clock. It recovers a factor from a product plus the other factor, or performs general 16/8 division.
- Uses the same start/busy handshake as `mul`, so the two can share one controller.
- Sits beside `mul` in the arithmetic datapath.

Parameters:
- A_W, 16, dividend and quotient width.
- B_W, 8, divisor and remainder width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high. Clears all state immediately.
- a_bi  in  A_W  dividend; sampled when a start is accepted.
- b_bi  in  B_W  divisor; sampled when a start is accepted.
- start_i  in  1  start request; honoured only in IDLE.
- busy_o  out  1  high while in WORK.
- y_bo  out  A_W  quotient; registered and held until the next completion.
- r_bo  out  B_W  remainder; registered and held until the next completion.
- dz_o  out  1  divide-by-zero flag for the last completed operation.
- done_o  out  1  one-cycle pulse when y_bo/r_bo/dz_o update.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, ctr=0, internal a/b/rem/q=0.
  - y_bo=0, r_bo=0, dz_o=0, done_o=0, busy_o=0.
  - Applies at any time, including mid-operation. The operation is abandoned and no done_o is issued.
- States: IDLE, WORK. busy_o = (state==WORK), purely decoded from state.
- IDLE, start_i=1, b_bi!=0 (edge N):
  - Latch a=a_bi, b=b_bi; rem(B_W+1 bits)=0; q=0; ctr=0.
  - state -> WORK.
  - dz_o is not touched until completion.
- IDLE, start_i=1, b_bi==0 (divide-by-zero fast path):
  - Stay in IDLE; busy_o never asserts.
  - At edge N: y_bo=all ones (16'hFFFF), r_bo=a_bi[B_W-1:0], dz_o=1, done_o=1 for one cycle.
- WORK step (each edge, ctr = 0..A_W-1):
  - t = {rem[B_W-1:0], a[A_W-1-ctr]} (B_W+1 bits).
  - If t >= {1'b0,b}: rem=t-b and q bit[A_W-1-ctr]=1. Otherwise rem=t and q bit=0.
  - ctr increments.
  - Equivalent shift-register implementation (shift a/q left each step) is acceptable if results are identical.
- Completion, on the step with ctr==A_W-1:
  - state -> IDLE.
  - y_bo = final q, r_bo = final rem[B_W-1:0], dz_o=0, done_o=1 for exactly that cycle.
- Latency:
  - Start accepted at edge N; busy_o high from after edge N to after edge N+A_W (16 cycles).
  - Results and done_o visible after edge N+A_W.
- done_o is 0 in every cycle other than a completion cycle.
- start_i while in WORK is ignored. Inputs a_bi/b_bi may change freely after acceptance.
- start_i high in the cycle right after completion is accepted (back-to-back, 17-cycle throughput). The previous result is held until the new completion.
- ctr wraps to 0 on completion. No residual state leaks between operations.
- Invariants, checked by the bench:
  - a == y_bo*b + r_bo and r_bo < b whenever dz_o=0.
  - rem never exceeds b-1 after a step.

Test Plan:
- Basic division: reset, then start a=1000, b=7 → busy_o high 16 cycles; done_o pulse; y_bo=142, r_bo=6, dz_o=0.
- Large dividend and max divisor: a=16'hFFFF, b=8'hFF → y_bo=257, r_bo=0. Then a=16'hABCD, b=1 → y_bo=16'hABCD, r_bo=0.
- Divisor exceeds dividend: a=100, b=200 → y_bo=0, r_bo=100.
- Divide by zero: a=16'h1234, b=0 → y_bo=16'hFFFF, r_bo=8'h34, dz_o=1, done_o after 1 edge, busy_o never high. Next a=9, b=3 → y_bo=3, r_bo=0, dz_o=0.
- Handshake:
  - Start a=500, b=3; pulse start_i again mid-WORK with a=1, b=1 → ignored; y_bo=166, r_bo=2.
  - Hold start_i high through completion with a=50, b=5 → second op starts immediately, y_bo=10 after 16 more cycles.
- Reset mid-operation: assert rst_i asynchronously (between edges) at cycle 8 of a=1000, b=7 → outputs 0 and busy_o=0 immediately, no done_o. A subsequent start produces correct results.
